// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the intersection lamp bus: phase encoding, the four
// legal active-low lamp patterns (also used by the controller), the monitor
// fault codes, and the monitor FSM state encoding.
// -----------------------------------------------------------------------------
package traffic_pkg;

    // Phase of the intersection as seen on the lamps.
    typedef enum logic [1:0] {
        PH_AG = 2'd0,   // road A green, road B red
        PH_AY = 2'd1,   // road A yellow, road B red
        PH_BG = 2'd2,   // road A red, road B green
        PH_BY = 2'd3    // road A red, road B yellow
    } phase_t;

    // Active-low lamp patterns: [5]=R_A [4]=Y_A [3]=G_A [2]=R_B [1]=Y_B [0]=G_B
    localparam logic [5:0] PAT_AG = 6'b110011;
    localparam logic [5:0] PAT_AY = 6'b101011;
    localparam logic [5:0] PAT_BG = 6'b011110;
    localparam logic [5:0] PAT_BY = 6'b011101;

    // Fault codes reported on fault_code.
    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_ILLEGAL = 3'd1;
    localparam logic [2:0] FC_SEQ     = 3'd2;
    localparam logic [2:0] FC_SHORT   = 3'd3;
    localparam logic [2:0] FC_LONG    = 3'd4;

    // Monitor FSM states.
    typedef enum logic [1:0] {
        MON_SYNC    = 2'd0,
        MON_ACQUIRE = 2'd1,
        MON_TRACK   = 2'd2,
        MON_FAULT   = 2'd3
    } mon_state_t;

    // The only legal successor of each phase: AG -> AY -> BG -> BY -> AG.
    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            PH_AG:   n = PH_AY;
            PH_AY:   n = PH_BG;
            PH_BG:   n = PH_BY;
            PH_BY:   n = PH_AG;
            default: n = PH_AG;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_lamp_decode.sv
// -----------------------------------------------------------------------------
// traffic_lamp_decode
// Pure combinational decode of the active-low lamp bus into a phase.
// Ports:
//   lamps  in  6  lamp bus, active-low
//   legal  out 1  lamps matches one of the four legal patterns
//   phase  out 2  decoded phase (PH_AG when not legal)
// -----------------------------------------------------------------------------
module traffic_lamp_decode
    import traffic_pkg::*;
(
    input  logic [5:0] lamps,
    output logic       legal,
    output phase_t     phase
);

    // Match the bus against the four legal patterns; anything else is illegal.
    always_comb begin
        legal = 1'b1;
        phase = PH_AG;
        case (lamps)
            PAT_AG:  phase = PH_AG;
            PAT_AY:  phase = PH_AY;
            PAT_BG:  phase = PH_BG;
            PAT_BY:  phase = PH_BY;
            default: begin
                legal = 1'b0;
                phase = PH_AG;
            end
        endcase
    end

endmodule

// File: rtl/traffic_monitor.sv
// -----------------------------------------------------------------------------
// traffic_monitor
// Lamp-side checker for the intersection controller. Decodes the lamp bus on
// each tick, checks the phase order and the dwell time of every phase, and
// latches the first violation as a sticky fault until clr_fault.
// Ports:
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   tick         in   1  one-clk controller step enable
//   lamps        in   6  active-low lamp bus
//   clr_fault    in   1  clears the fault and restarts acquisition
//   phase        out  2  decoded phase 0=AG 1=AY 2=BG 3=BY
//   phase_valid  out  1  monitor is in ACQUIRE or TRACK
//   dwell        out  5  ticks spent in the current phase, saturating
//   fault        out  1  sticky violation flag
//   fault_code   out  3  first violation code
//   cycle_cnt    out 16  completed full cycles, wrapping
// Build option: define TRAFFIC_MON_SYNC_EN to put lamps through a 2-flop
// synchronizer (tick delayed to match), giving 3 clk latency instead of 1.
// -----------------------------------------------------------------------------
module traffic_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_T   = 32'd10,
    parameter int unsigned YELLOW_T  = 32'd3,
    parameter int unsigned RED_T     = 32'd15,
    parameter int unsigned DWELL_TOL = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic [5:0]  lamps,
    input  logic        clr_fault,
    output logic [1:0]  phase,
    output logic        phase_valid,
    output logic [4:0]  dwell,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [15:0] cycle_cnt
);

    // Dwell windows per phase; the lower bound is clamped at zero.
    localparam logic [31:0] LONG_G  = GREEN_T  + 32'd1 + DWELL_TOL;
    localparam logic [31:0] LONG_Y  = YELLOW_T + 32'd1 + DWELL_TOL;
    localparam logic [31:0] LONG_R  = RED_T    + 32'd1 + DWELL_TOL;
    localparam logic [31:0] SHORT_G = (GREEN_T  + 32'd1 > DWELL_TOL) ? (GREEN_T  + 32'd1 - DWELL_TOL) : 32'd0;
    localparam logic [31:0] SHORT_Y = (YELLOW_T + 32'd1 > DWELL_TOL) ? (YELLOW_T + 32'd1 - DWELL_TOL) : 32'd0;
    localparam logic [31:0] SHORT_R = (RED_T    + 32'd1 > DWELL_TOL) ? (RED_T    + 32'd1 - DWELL_TOL) : 32'd0;

    logic [5:0]  lamps_s;
    logic        tick_s;
    logic        legal_s;
    phase_t      dec_phase_s;

    mon_state_t  state_r;
    mon_state_t  next_state_s;
    phase_t      phase_r;
    phase_t      phase_nxt_s;
    logic [4:0]  dwell_r;
    logic [4:0]  dwell_nxt_s;
    logic [4:0]  dwell_inc_s;
    logic        fault_r;
    logic        fault_nxt_s;
    logic [2:0]  code_r;
    logic [2:0]  code_nxt_s;
    logic [15:0] cycle_r;
    logic [15:0] cycle_nxt_s;
    logic        valid_r;
    logic        valid_nxt_s;

    logic [31:0] long_lim_s;
    logic [31:0] short_lim_s;
    logic        same_s;
    logic        succ_s;
    logic [2:0]  viol_s;

`ifdef TRAFFIC_MON_SYNC_EN
    logic [5:0] lamps_m_r;
    logic [5:0] lamps_q_r;
    logic [1:0] tick_d_r;

    // Two-flop synchronizer on the lamp bus, with tick delayed to stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lamps_m_r <= 6'b111111;
            lamps_q_r <= 6'b111111;
            tick_d_r  <= 2'b00;
        end else begin
            lamps_m_r <= lamps;
            lamps_q_r <= lamps_m_r;
            tick_d_r  <= {tick_d_r[0], tick};
        end
    end

    assign lamps_s = lamps_q_r;
    assign tick_s  = tick_d_r[1];
`else
    assign lamps_s = lamps;
    assign tick_s  = tick;
`endif

    traffic_lamp_decode u_decode (
        .lamps (lamps_s),
        .legal (legal_s),
        .phase (dec_phase_s)
    );

    assign dwell_inc_s = (dwell_r == 5'd31) ? 5'd31 : (dwell_r + 5'd1);

    // Dwell window for the phase currently being tracked.
    always_comb begin
        long_lim_s  = LONG_G;
        short_lim_s = SHORT_G;
        case (phase_r)
            PH_AG: begin
                long_lim_s  = LONG_G;
                short_lim_s = SHORT_G;
            end
            PH_AY, PH_BY: begin
                long_lim_s  = LONG_Y;
                short_lim_s = SHORT_Y;
            end
            PH_BG: begin
                long_lim_s  = LONG_R;
                short_lim_s = SHORT_R;
            end
            default: begin
                long_lim_s  = LONG_G;
                short_lim_s = SHORT_G;
            end
        endcase
    end

    // Violation seen by this tick; the if-chain order gives priority 1>2>3>4.
    // The short check only applies in TRACK since the acquired phase is partial.
    always_comb begin
        same_s = (dec_phase_s == phase_r);
        succ_s = (dec_phase_s == next_phase(phase_r));
        viol_s = FC_NONE;
        if (!legal_s) begin
            viol_s = FC_ILLEGAL;
        end else if (same_s) begin
            if ({27'd0, dwell_inc_s} > long_lim_s) begin
                viol_s = FC_LONG;
            end else begin
                viol_s = FC_NONE;
            end
        end else if (!succ_s) begin
            viol_s = FC_SEQ;
        end else if ((state_r == MON_TRACK) && ({27'd0, dwell_r} < short_lim_s)) begin
            viol_s = FC_SHORT;
        end else begin
            viol_s = FC_NONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= MON_SYNC;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state; clr_fault overrides any tick in the same cycle.
    always_comb begin
        next_state_s = state_r;
        if (clr_fault) begin
            next_state_s = MON_SYNC;
        end else if (tick_s) begin
            case (state_r)
                MON_SYNC: begin
                    if (legal_s) begin
                        next_state_s = MON_ACQUIRE;
                    end else begin
                        next_state_s = MON_SYNC;
                    end
                end
                MON_ACQUIRE, MON_TRACK: begin
                    if (viol_s != FC_NONE) begin
                        next_state_s = MON_FAULT;
                    end else if (!same_s) begin
                        next_state_s = MON_TRACK;
                    end else begin
                        next_state_s = state_r;
                    end
                end
                MON_FAULT: next_state_s = MON_FAULT;
                default:   next_state_s = MON_SYNC;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // FSM outputs: next values of the registered outputs.
    always_comb begin
        phase_nxt_s = phase_r;
        dwell_nxt_s = dwell_r;
        fault_nxt_s = fault_r;
        code_nxt_s  = code_r;
        cycle_nxt_s = cycle_r;
        if (clr_fault) begin
            dwell_nxt_s = 5'd0;
            fault_nxt_s = 1'b0;
            code_nxt_s  = FC_NONE;
        end else if (tick_s) begin
            case (state_r)
                MON_SYNC: begin
                    if (legal_s) begin
                        phase_nxt_s = dec_phase_s;
                        dwell_nxt_s = 5'd1;
                    end else begin
                        phase_nxt_s = phase_r;
                    end
                end
                MON_ACQUIRE, MON_TRACK: begin
                    if (viol_s != FC_NONE) begin
                        fault_nxt_s = 1'b1;
                        code_nxt_s  = viol_s;
                        // an over-long phase still shows the tick that broke it
                        if (viol_s == FC_LONG) begin
                            dwell_nxt_s = dwell_inc_s;
                        end else begin
                            dwell_nxt_s = dwell_r;
                        end
                    end else if (same_s) begin
                        dwell_nxt_s = dwell_inc_s;
                    end else begin
                        phase_nxt_s = dec_phase_s;
                        dwell_nxt_s = 5'd1;
                        // a full cycle closes only on a tracked BY -> AG change
                        if ((state_r == MON_TRACK) && (phase_r == PH_BY)) begin
                            cycle_nxt_s = cycle_r + 16'd1;
                        end else begin
                            cycle_nxt_s = cycle_r;
                        end
                    end
                end
                MON_FAULT: phase_nxt_s = phase_r;
                default:   phase_nxt_s = phase_r;
            endcase
        end else begin
            phase_nxt_s = phase_r;
        end
        valid_nxt_s = (next_state_s == MON_ACQUIRE) || (next_state_s == MON_TRACK);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= PH_AG;
            dwell_r <= 5'd0;
            fault_r <= 1'b0;
            code_r  <= FC_NONE;
            cycle_r <= 16'd0;
            valid_r <= 1'b0;
        end else begin
            phase_r <= phase_nxt_s;
            dwell_r <= dwell_nxt_s;
            fault_r <= fault_nxt_s;
            code_r  <= code_nxt_s;
            cycle_r <= cycle_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign phase       = phase_r;
    assign phase_valid = valid_r;
    assign dwell       = dwell_r;
    assign fault       = fault_r;
    assign fault_code  = code_r;
    assign cycle_cnt   = cycle_r;

endmodule

// File: doc/traffic_monitor.md
# traffic_monitor

Lamp-side checker for the intersection controller. Watches the 6-bit active-low lamp bus the controller drives and decodes it back into a phase. Checks each phase change against the legal sequence and each phase duration against the programmed dwell times. Latches the first violation as a sticky fault for the board status LEDs and the safety cut-off.

## Interface
- GREEN_T, 10: controller green count; expected green dwell = GREEN_T+1 ticks
- YELLOW_T, 3: controller yellow count; expected yellow dwell = YELLOW_T+1 ticks
- RED_T, 15: controller red count (other road green); expected dwell = RED_T+1 ticks
- DWELL_TOL, 0: allowed ± deviation in ticks on every dwell check
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- tick  in  1  one-clk-wide enable, one pulse per controller step (1 Hz)
- lamps  in  6  lamp bus, active-low: [5]=R_A [4]=Y_A [3]=G_A [2]=R_B [1]=Y_B [0]=G_B
- clr_fault  in  1  one-clk pulse; clears the fault and restarts acquisition
- phase  out  2  decoded phase: 0=AG, 1=AY, 2=BG, 3=BY
- phase_valid  out  1  high in ACQUIRE/TRACK
- dwell  out  5  ticks spent in the current phase, saturating at 31
- fault  out  1  sticky violation flag
- fault_code  out  3  0 none, 1 illegal pattern, 2 bad sequence, 3 dwell short, 4 dwell long
- cycle_cnt  out  16  completed full cycles; wraps 0xFFFF→0

## Operation
- Legal patterns: AG=6'b110011, AY=6'b101011, BG=6'b011110, BY=6'b011101. Any other value is illegal.
- Legal successors: AG→AY→BG→BY→AG.
- Expected dwell E(p): AG=GREEN_T+1, AY=YELLOW_T+1, BG=RED_T+1, BY=YELLOW_T+1.
- Lamps are evaluated only on tick cycles. Non-tick cycles hold all state.
- FSM states are SYNC, ACQUIRE, TRACK and FAULT. Reset enters SYNC.
- SYNC:
  - Illegal patterns are ignored.
  - First legal pattern → ACQUIRE, phase=p, dwell=1.
- ACQUIRE:
  - The first phase is partial, so dwell-short is not checked.
  - Same phase: dwell++. Dwell > E+TOL → fault 4.
  - Legal successor → TRACK, dwell=1.
  - Illegal pattern → fault 1. Wrong successor → fault 2.
- TRACK:
  - Same phase: dwell++. Dwell > E+TOL → fault 4 on that tick.
  - Phase change: wrong successor → fault 2. Otherwise, dwell < E−TOL → fault 3.
  - Legal change with dwell ok: phase updates, dwell=1.
  - BY→AG legal change: cycle_cnt++.
  - Illegal pattern → fault 1.
- Fault priority within one tick: 1 > 2 > 3 > 4.
- Entering FAULT:
  - fault=1 and fault_code are latched. phase_valid=0.
  - phase and dwell freeze.
  - Later violations do not overwrite fault_code.
- FAULT exit: clr_fault → SYNC with fault=0, fault_code=0 and dwell=0. cycle_cnt is kept.
- clr_fault together with a tick in a non-FAULT state: clr_fault wins. The FSM returns to SYNC and that tick is discarded.
- Dwell arithmetic is 5-bit unsigned and saturates at 31. Comparisons are unsigned; E−TOL is clamped at 0.

## Timing
- Reset (async assert, sync release) values: phase=0, phase_valid=0, dwell=0, fault=0, fault_code=0, cycle_cnt=0, FSM=SYNC.
- All outputs are registered. The effect of a tick is visible 1 clk after the tick cycle (latency 1; 3 with TRAFFIC_MON_SYNC_EN).
- rst_n low mid-operation clears everything immediately, regardless of clk.
- tick pulses on consecutive clk cycles are each evaluated. No minimum spacing is required.

## Configuration
- TRAFFIC_MON_SYNC_EN defined:
  - lamps passes through a 2-flop synchronizer before decode.
  - tick is delayed by 2 flops to stay aligned with lamps.
  - Latency becomes 3 clk.
- Not defined: lamps and tick are used directly (source is synchronous to clk), latency 1.

## Structure
- Package traffic_pkg holds:
  - the phase typedef (2-bit enum AG/AY/BG/BY)
  - the four lamp-pattern constants
  - the fault-code constants
  - the monitor FSM state enum
- The controller shares the same pattern constants.
- Sub-module traffic_lamp_decode: lamps[5:0] → {legal, phase[1:0]}. Pure decode, instantiated once.

## Test plan
- Nominal run: after reset, drive AG 5 ticks, AY 4, BG 16, BY 4, AG 11, AY 4 (defaults).
  - phase_valid rises 1 clk after the first tick.
  - fault stays 0.
  - cycle_cnt=1 after the BY→AG tick.
- Long yellow: in TRACK, hold AY for 5 ticks → fault=1, fault_code=4 one clk after the 5th tick; dwell frozen at 5.
- Bad sequence and priority:
  - In TRACK after AG held 11 ticks, drive BG → fault_code=2.
  - Repeat with AG held 3 ticks → still code 2 (beats code 3).
- Short red: in TRACK, BG for 10 ticks then BY → fault_code=3.
- Illegal pattern:
  - 6'b000000 in SYNC → ignored, phase_valid=0.
  - 6'b000000 in TRACK → fault_code=1.
  - A later legal-sequence violation leaves the code at 1.
- Recovery and reset:
  - clr_fault in FAULT → fault=0, FSM=SYNC, cycle_cnt unchanged.
  - rst_n low mid-TRACK, between clk edges → all outputs 0 immediately.
